// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 data RAM slice.
package jtdsp16_pkg;

    localparam int JTDSP16_RAM_AW = 11;
    localparam int JTDSP16_DW     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XRD  = 1'b1
    } state_t;

    // Which register currently drives dout.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_ARR  = 2'd1,
        SRC_WT   = 2'd2
    } src_t;

endpackage

// File: rtl/jtdsp16_dram_array.sv
// 2**AW x DW single-port RAM with synchronous read.
// JTDSP16_DRAM_DBG_EN adds a free-running registered debug read port.
module jtdsp16_dram_array #(
    parameter int    AW        = 11,
    parameter int    DW        = 16,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
`ifdef JTDSP16_DRAM_DBG_EN
    ,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_dout
`endif
);

    logic [DW-1:0] mem [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) q <= mem[addr];
    end

`ifdef JTDSP16_DRAM_DBG_EN
    // Read-first: a same-clk write to this word shows up one clk later.
    always_ff @(posedge clk) dbg_dout <= mem[dbg_addr];
`endif

endmodule

// File: rtl/jtdsp16_dram.sv
// JTDSP16 data RAM stage: read/write/exchange with write-through.
// JTDSP16_DRAM_DBG_EN adds the dbg_addr/dbg_dout debug read port.
module jtdsp16_dram
    import jtdsp16_pkg::*;
#(
    parameter int    AW        = JTDSP16_RAM_AW,
    parameter int    DW        = JTDSP16_DW,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ph1,
    input  logic [AW-1:0] ram_addr,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic          xchg,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy
`ifdef JTDSP16_DRAM_DBG_EN
    ,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_dout
`endif
);

    state_t        st, st_nx;
    src_t          src;
    logic [AW-1:0] addr_l, arr_addr;
    logic [DW-1:0] din_l, wt_q, arr_din, arr_q;
    logic          arr_we, arr_re, wt_ld, rd_any, lat_ld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_IDLE;
        else if (ph1) st <= st_nx;
    end

    always_comb begin
        st_nx    = st;
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        wt_ld    = 1'b0;
        rd_any   = 1'b0;
        lat_ld   = 1'b0;
        arr_addr = ram_addr;
        arr_din  = din;
        if (ph1 && rst) begin
            unique case (st)
                ST_IDLE: begin
                    if (xchg) begin
                        arr_re = 1'b1;
                        rd_any = 1'b1;
                        lat_ld = 1'b1;
                        st_nx  = ST_XRD;
                    end else begin
                        arr_we = wr_en;
                        arr_re = rd_en & ~wr_en;
                        wt_ld  = rd_en & wr_en;
                        rd_any = rd_en;
                    end
                end
                ST_XRD: begin
                    arr_we   = 1'b1;
                    arr_addr = addr_l;
                    arr_din  = din_l;
                    st_nx    = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src      <= SRC_ZERO;
            dout_vld <= 1'b0;
            wt_q     <= '0;
            addr_l   <= '0;
            din_l    <= '0;
        end else if (ph1) begin
            dout_vld <= rd_any;
            if (wt_ld) begin
                wt_q <= din;
                src  <= SRC_WT;
            end else if (arr_re) begin
                src <= SRC_ARR;
            end
            if (lat_ld) begin
                addr_l <= ram_addr;
                din_l  <= din;
            end
        end
    end

    always_comb begin
        unique case (src)
            SRC_ARR: dout = arr_q;
            SRC_WT:  dout = wt_q;
            default: dout = '0;
        endcase
    end

    assign busy = (st == ST_XRD);

    jtdsp16_dram_array #(
        .AW       (AW),
        .DW       (DW),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk     (clk),
        .addr    (arr_addr),
        .we      (arr_we),
        .re      (arr_re),
        .din     (arr_din),
        .q       (arr_q)
`ifdef JTDSP16_DRAM_DBG_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_dout(dbg_dout)
`endif
    );

endmodule

// File: tb/tb_jtdsp16_dram.sv
// Self-checking bench for jtdsp16_dram: directed scenarios plus random traffic.
module tb_jtdsp16_dram;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, ph1, rd_en, wr_en, xchg;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] din, dout;
    logic          dout_vld, busy;
`ifdef JTDSP16_DRAM_DBG_EN
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_dout;
`endif

    jtdsp16_dram dut (
        .clk     (clk),
        .rst     (rst),
        .ph1     (ph1),
        .ram_addr(ram_addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .xchg    (xchg),
        .din     (din),
        .dout    (dout),
        .dout_vld(dout_vld),
        .busy    (busy)
`ifdef JTDSP16_DRAM_DBG_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_dout(dbg_dout)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: memory contents plus the visible outputs.
    logic [DW-1:0] m_mem [0:2**AW-1];
    logic [DW-1:0] m_dout;
    logic          m_vld, m_busy;
    logic [AW-1:0] m_al;
    logic [DW-1:0] m_dl;

    task automatic model_reset();
        m_dout = '0;
        m_vld  = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic step(input logic p, input logic [AW-1:0] a,
                        input logic r, input logic w, input logic x,
                        input logic [DW-1:0] d);
        ph1 = p; ram_addr = a; rd_en = r; wr_en = w; xchg = x; din = d;
        @(posedge clk);
        if (p && rst) begin
            if (m_busy) begin
                m_mem[m_al] = m_dl;
                m_busy = 1'b0;
                m_vld  = 1'b0;
            end else if (x) begin
                m_dout = m_mem[a];
                m_vld  = 1'b1;
                m_al   = a;
                m_dl   = d;
                m_busy = 1'b1;
            end else if (w) begin
                m_mem[a] = d;
                if (r) m_dout = d;
                m_vld = r;
            end else if (r) begin
                m_dout = m_mem[a];
                m_vld  = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        step(1'b1, 11'h005, 1'b1, 1'b1, 1'b0, 16'hDEAD);
        step(1'b1, 11'h006, 1'b0, 1'b0, 1'b1, 16'hBEAD);
        tests++;
        if (dout !== 16'h0000 || dout_vld !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset: dout=%h vld=%b busy=%b required 0000/0/0",
                     dout, dout_vld, busy);
            fails++;
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_write_read();
        step(1'b1, 11'h7FF, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        tests++;
        if (dout_vld !== 1'b0) begin
            $display("FAIL wr_novld: vld=%b required 0", dout_vld);
            fails++;
        end
        step(1'b1, 11'h7FF, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'hBEEF || dout_vld !== 1'b1) begin
            $display("FAIL wr_rd: dout=%h vld=%b required beef/1", dout, dout_vld);
            fails++;
        end
        idle();
        tests++;
        if (dout !== 16'hBEEF || dout_vld !== 1'b0) begin
            $display("FAIL rd_hold: dout=%h vld=%b required beef/0", dout, dout_vld);
            fails++;
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 11'h010, 1'b1, 1'b1, 1'b0, 16'h1234);
        tests++;
        if (dout !== 16'h1234 || dout_vld !== 1'b1) begin
            $display("FAIL wt_thru: dout=%h vld=%b required 1234/1", dout, dout_vld);
            fails++;
        end
        idle();
        step(1'b1, 11'h7FF, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 11'h010, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'h1234) begin
            $display("FAIL wt_mem: dout=%h required 1234", dout);
            fails++;
        end
    endtask

    task automatic test_exchange();
        step(1'b1, 11'h021, 1'b0, 1'b1, 1'b0, 16'h0123);
        step(1'b1, 11'h020, 1'b0, 1'b1, 1'b0, 16'h5555);
        step(1'b1, 11'h020, 1'b1, 1'b1, 1'b1, 16'hAAAA);
        tests++;
        if (dout !== 16'h5555 || dout_vld !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL xchg_rd: dout=%h vld=%b busy=%b required 5555/1/1",
                     dout, dout_vld, busy);
            fails++;
        end
        // Address moves and a read arrives while busy; both must be ignored.
        step(1'b1, 11'h021, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'h5555 || dout_vld !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL busy_drop: dout=%h vld=%b busy=%b required 5555/0/0",
                     dout, dout_vld, busy);
            fails++;
        end
        step(1'b1, 11'h020, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'hAAAA) begin
            $display("FAIL xchg_wr: mem[020]=%h required aaaa", dout);
            fails++;
        end
        step(1'b1, 11'h021, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'h0123) begin
            $display("FAIL xchg_nbr: mem[021]=%h required 0123", dout);
            fails++;
        end
    endtask

    task automatic test_stall();
        step(1'b1, 11'h040, 1'b0, 1'b1, 1'b0, 16'h0F0F);
        step(1'b1, 11'h040, 1'b0, 1'b0, 1'b1, 16'hF0F0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 11'h040, 1'b1, 1'b1, 1'b1, 16'h9999);
            tests++;
            if (busy !== 1'b1 || dout !== 16'h0F0F || dout_vld !== 1'b1) begin
                $display("FAIL stall_%0d: busy=%b dout=%h vld=%b required 1/0f0f/1",
                         i, busy, dout, dout_vld);
                fails++;
            end
        end
        idle();
        tests++;
        if (busy !== 1'b0) begin
            $display("FAIL stall_end: busy=%b required 0", busy);
            fails++;
        end
        step(1'b1, 11'h040, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'hF0F0) begin
            $display("FAIL stall_wr: mem[040]=%h required f0f0", dout);
            fails++;
        end
    endtask

    task automatic test_reset_mid_xchg();
        step(1'b1, 11'h030, 1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b1, 11'h030, 1'b0, 1'b0, 1'b1, 16'h2222);
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (busy !== 1'b0 || dout !== 16'h0000 || dout_vld !== 1'b0) begin
            $display("FAIL rst_mid: busy=%b dout=%h vld=%b required 0/0000/0",
                     busy, dout, dout_vld);
            fails++;
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        idle();
        step(1'b1, 11'h030, 1'b1, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (dout !== 16'h1111) begin
            $display("FAIL rst_keep: mem[030]=%h required 1111", dout);
            fails++;
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic          p, r, w, x;
        for (int i = 0; i < 16; i++)
            step(1'b1, AW'(11'h100 + i), 1'b0, 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 300; i++) begin
            p = ($urandom_range(0, 3) != 0);
            a = AW'(11'h100 + $urandom_range(0, 15));
            r = 1'($urandom);
            w = 1'($urandom);
            x = ($urandom_range(0, 3) == 0);
            step(p, a, r, w, x, DW'($urandom));
            tests++;
            if (dout !== m_dout || dout_vld !== m_vld || busy !== m_busy) begin
                $display("FAIL rand_%0d: dout=%h vld=%b busy=%b required %h/%b/%b",
                         i, dout, dout_vld, busy, m_dout, m_vld, m_busy);
                fails++;
            end
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, AW'(11'h100 + i), 1'b1, 1'b0, 1'b0, '0);
            tests++;
            if (dout !== m_mem[11'h100 + i]) begin
                $display("FAIL rand_mem_%0d: got %h required %h",
                         i, dout, m_mem[11'h100 + i]);
                fails++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; ph1 = 1'b0; rd_en = 1'b0; wr_en = 1'b0; xchg = 1'b0;
        ram_addr = '0; din = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_simultaneous();
        test_exchange();
        test_stall();
        test_reset_mid_xchg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
